pwm_sequencer: RTL and testbench
================================

# pwm_sequencer

Pointwise-multiplication (PWM) sequencer for the RNS/NTT polynomial datapath. It streams one coefficient index per cycle from three coefficient BRAMs: polynomial a, and duplicated polynomials b0/b1 and c0/c1. It feeds two borrowed NTT butterflies, BF0 and BF2 of UnifiedTransformation, and writes their outputs to two result BRAMs, result0/result1. The block contains no modular arithmetic: the butterflies compute (ina + inb·tw) mod q_k, so each result is r_j[i] = (c_j[i] + b_j[i]·a[i]) mod q_k.

## Interface
Parameters:
- LOGQ, 54: coefficient / modulus width.
- LOGN, 13: log2 of ring dimension; N = 2^LOGN coefficients.
- W, 24: modulus shape parameter, passed through only.
- M, 17: width of q_m.
- RD_LAT, 3: cycles from BRAM read address to valid butterfly inputs (2 BRAM cycles + 1 input register).
- BF_LAT, 7: butterfly latency, inputs to pwm_bf*_result.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous and active-low. Deassertion starts one pass.
- q_m, in, M: modulus descriptor. The butterfly consumes it; this block ignores it.
- current_k, in, 4: RNS modulus index. Ignored by this block.
- a_bram_rd_addr, out, LOGN: read address for a.
- a_bram_rd_data, in, LOGQ: data for a.
- b_bram_rd_addr, out, LOGN: read address shared by b0 and b1.
- b0_bram_rd_data, in, LOGQ: data for b0.
- b1_bram_rd_data, in, LOGQ: data for b1.
- c_bram_rd_addr, out, LOGN: read address shared by c0 and c1.
- c0_bram_rd_data, in, LOGQ: data for c0.
- c1_bram_rd_data, in, LOGQ: data for c1.
- result_bram_wr_addr, out, LOGN: write address shared by both result BRAMs.
- result_bram_wea, out, 1: write enable shared by both result BRAMs.
- result0_bram_wr_data, out, LOGQ: write data for result0.
- result1_bram_wr_data, out, LOGQ: write data for result1.
- pwm_bf0_ina, out, LOGQ: BF0 addend input, driven with c0.
- pwm_bf0_inb, out, LOGQ: BF0 multiplicand input, driven with b0.
- pwm_bf0_tw, out, LOGQ: BF0 twiddle input, driven with a.
- pwm_bf0_result, in, LOGQ: BF0 output.
- pwm_bf1_ina, pwm_bf1_inb, pwm_bf1_tw, pwm_bf1_result: same as the BF0 set, using c1/b1/a; connects to BF2 of the transformation.
- done, out, 1: pass complete; held high until reset.

## Operation
- States: IDLE (held in reset), RUN, DRAIN, DONE.
- In reset, all outputs are 0: addresses, wea, write data, butterfly inputs and done.
- On rst rising, the state moves IDLE→RUN.
- RUN:
  - A single read counter rd_cnt drives all three read addresses with the same value.
  - It starts at 0 and increments by 1 per cycle.
  - After issuing N-1, the state moves to DRAIN.
- Input registers:
  - The butterfly inputs are registers loaded from the BRAM data: ina←c_j, inb←b_j, tw←a.
  - They are valid RD_LAT cycles after the address is issued.
- A valid/address shift register of depth RD_LAT+BF_LAT carries each read address.
- Write-back:
  - When the shifted valid bit emerges, drive wea=1 with result_bram_wr_addr equal to the shifted address.
  - result0_bram_wr_data = pwm_bf0_result and result1_bram_wr_data = pwm_bf1_result, taken combinationally from the butterfly outputs in that cycle.
- DRAIN:
  - Read addresses stay at N-1; further reads are don't-care.
  - After the write to address N-1, the state moves to DONE.
- DONE:
  - done=1, wea=0. The block stays there until rst goes low.
  - There is no restart without reset.
- Boundaries:
  - Address N-1 is processed exactly once; there is no wrap to 0.
  - Reset mid-pass aborts immediately; wea drops asynchronously and no further writes occur.
  - Both lanes always write the same address in the same cycle.

## Timing
- Cycle 0 is the first rising edge after rst deasserts: rd_addr = 0.
- Cycle t: rd_addr = t, for 0 ≤ t ≤ N-1.
- Butterfly inputs for index t are valid at cycle t+RD_LAT.
- Write of index t happens at cycle t+RD_LAT+BF_LAT with wea=1.
- wea is high for exactly N consecutive cycles.
- done rises at cycle N+RD_LAT+BF_LAT, one cycle after the last write; 8202 with defaults.
- Throughput is 1 coefficient per lane per cycle, with no stalls.
- The caller must hold q_m and current_k stable for the whole pass.

## Test plan
- Reset values: hold rst=0 → all outputs 0; done=0, wea=0.
- Address sequence: release rst → rd addresses 0..8191 on cycles 0..8191; wea first high at cycle 10 with wr_addr=0; last write at cycle 8201 with wr_addr=8191; done=1 at cycle 8202 and stays high.
- Data steering with a stub butterfly (result = ina + inb·tw, latency BF_LAT), a[i]=i, b[i]=2, c[i]=1 → result0[i] = result1[i] = 2i+1 for all i.
- Lane independence: b1=b0+1, c1=0 → result1[i] = a[i]·(b0[i]+1) while result0 is unchanged.
- Full system with UnifiedTransformation, q_k = 2^54 − qm·2^24 + 1 and random operands → both result BRAMs equal (c + a·b) mod q_k for every index.
- Mid-pass reset: assert rst low at cycle 4000 → outputs 0 at once, done stays 0, result BRAM addresses ≥ 3990 untouched.

Source files
------------

// File: rtl/pwm_sequencer.sv
// Streams coefficient indices 0..N-1 through two pointwise-multiply butterfly lanes into the result BRAMs.
// Index t is read on cycle t and written on cycle t+RD_LAT+BF_LAT; one index per cycle, never stalls.
module pwm_sequencer #(
  parameter int LOGQ   = 54,
  parameter int LOGN   = 13,
  parameter int W      = 24,
  parameter int M      = 17,
  parameter int RD_LAT = 3,
  parameter int BF_LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M-1:0]    q_m,
  input  logic [3:0]      current_k,
  output logic [LOGN-1:0] a_bram_rd_addr,
  input  logic [LOGQ-1:0] a_bram_rd_data,
  output logic [LOGN-1:0] b_bram_rd_addr,
  input  logic [LOGQ-1:0] b0_bram_rd_data,
  input  logic [LOGQ-1:0] b1_bram_rd_data,
  output logic [LOGN-1:0] c_bram_rd_addr,
  input  logic [LOGQ-1:0] c0_bram_rd_data,
  input  logic [LOGQ-1:0] c1_bram_rd_data,
  output logic [LOGN-1:0] result_bram_wr_addr,
  output logic            result_bram_wea,
  output logic [LOGQ-1:0] result0_bram_wr_data,
  output logic [LOGQ-1:0] result1_bram_wr_data,
  output logic [LOGQ-1:0] pwm_bf0_ina,
  output logic [LOGQ-1:0] pwm_bf0_inb,
  output logic [LOGQ-1:0] pwm_bf0_tw,
  input  logic [LOGQ-1:0] pwm_bf0_result,
  output logic [LOGQ-1:0] pwm_bf1_ina,
  output logic [LOGQ-1:0] pwm_bf1_inb,
  output logic [LOGQ-1:0] pwm_bf1_tw,
  input  logic [LOGQ-1:0] pwm_bf1_result,
  output logic            done
);

  localparam int              DEPTH = RD_LAT + BF_LAT;
  localparam logic [LOGN-1:0] LAST  = {LOGN{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     r_state;
  logic [LOGN-1:0]            r_rd_cnt;
  logic [DEPTH-1:0]           r_vld_sr;
  logic [DEPTH-1:0][LOGN-1:0] r_addr_sr;
  logic                       r_done;
  logic [LOGQ-1:0]            r_bf0_ina, r_bf0_inb, r_bf0_tw;
  logic [LOGQ-1:0]            r_bf1_ina, r_bf1_inb, r_bf1_tw;

  logic                       w_wr_vld;
  logic [LOGN-1:0]            w_wr_addr;
  logic                       w_unused;

  assign w_wr_vld  = r_vld_sr[DEPTH-1];
  assign w_wr_addr = r_addr_sr[DEPTH-1];

  // The modulus only matters inside the butterflies.
  assign w_unused = ^{q_m, current_k, (W > 0)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_vld_sr  <= '0;
      r_addr_sr <= '0;
      r_done    <= 1'b0;
      r_bf0_ina <= '0;
      r_bf0_inb <= '0;
      r_bf0_tw  <= '0;
      r_bf1_ina <= '0;
      r_bf1_inb <= '0;
      r_bf1_tw  <= '0;
    end else begin
      r_vld_sr  <= {r_vld_sr[DEPTH-2:0], (r_state == RUN)};
      r_addr_sr <= {r_addr_sr[DEPTH-2:0], r_rd_cnt};
      r_bf0_ina <= c0_bram_rd_data;
      r_bf0_inb <= b0_bram_rd_data;
      r_bf0_tw  <= a_bram_rd_data;
      r_bf1_ina <= c1_bram_rd_data;
      r_bf1_inb <= b1_bram_rd_data;
      r_bf1_tw  <= a_bram_rd_data;
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          // Counter parks at N-1 so the last index is never followed by a wrap to 0.
          if (r_rd_cnt == LAST) r_state <= DRAIN;
          else                  r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        DRAIN: begin
          if (w_wr_vld && (w_wr_addr == LAST)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_done  <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_bram_rd_addr = r_rd_cnt;
  assign b_bram_rd_addr = r_rd_cnt;
  assign c_bram_rd_addr = r_rd_cnt;

  assign pwm_bf0_ina = r_bf0_ina;
  assign pwm_bf0_inb = r_bf0_inb;
  assign pwm_bf0_tw  = r_bf0_tw;
  assign pwm_bf1_ina = r_bf1_ina;
  assign pwm_bf1_inb = r_bf1_inb;
  assign pwm_bf1_tw  = r_bf1_tw;

  // Gating on the valid keeps stale butterfly outputs off the write bus outside a write.
  assign result_bram_wea      = w_wr_vld;
  assign result_bram_wr_addr  = w_wr_addr;
  assign result0_bram_wr_data = w_wr_vld ? pwm_bf0_result : '0;
  assign result1_bram_wr_data = w_wr_vld ? pwm_bf1_result : '0;

  assign done = r_done;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: BRAM and stub-butterfly models, cycle-exact timing checks and result memory sweeps.
`timescale 1ns/1ps
module tb_pwm_sequencer;
  localparam int LOGQ = 54, LOGN = 13, N = 1 << LOGN, W = 24, M = 17;
  localparam int RD_LAT = 3, BF_LAT = 7, LAT = RD_LAT + BF_LAT;
  localparam logic [M-1:0]  QM = 17'd12289;
  localparam logic [127:0]  Q  = (128'd1 << 54) - (128'(QM) << 24) + 128'd1;

  logic            clk, rst;
  logic [M-1:0]    q_m;
  logic [3:0]      current_k;
  logic [LOGN-1:0] a_bram_rd_addr, b_bram_rd_addr, c_bram_rd_addr, result_bram_wr_addr;
  logic [LOGQ-1:0] a_bram_rd_data, b0_bram_rd_data, b1_bram_rd_data, c0_bram_rd_data, c1_bram_rd_data;
  logic            result_bram_wea, done;
  logic [LOGQ-1:0] result0_bram_wr_data, result1_bram_wr_data;
  logic [LOGQ-1:0] pwm_bf0_ina, pwm_bf0_inb, pwm_bf0_tw, pwm_bf0_result;
  logic [LOGQ-1:0] pwm_bf1_ina, pwm_bf1_inb, pwm_bf1_tw, pwm_bf1_result;

  pwm_sequencer #(.LOGQ(LOGQ), .LOGN(LOGN), .W(W), .M(M), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .q_m(q_m), .current_k(current_k),
    .a_bram_rd_addr(a_bram_rd_addr), .a_bram_rd_data(a_bram_rd_data),
    .b_bram_rd_addr(b_bram_rd_addr), .b0_bram_rd_data(b0_bram_rd_data), .b1_bram_rd_data(b1_bram_rd_data),
    .c_bram_rd_addr(c_bram_rd_addr), .c0_bram_rd_data(c0_bram_rd_data), .c1_bram_rd_data(c1_bram_rd_data),
    .result_bram_wr_addr(result_bram_wr_addr), .result_bram_wea(result_bram_wea),
    .result0_bram_wr_data(result0_bram_wr_data), .result1_bram_wr_data(result1_bram_wr_data),
    .pwm_bf0_ina(pwm_bf0_ina), .pwm_bf0_inb(pwm_bf0_inb), .pwm_bf0_tw(pwm_bf0_tw), .pwm_bf0_result(pwm_bf0_result),
    .pwm_bf1_ina(pwm_bf1_ina), .pwm_bf1_inb(pwm_bf1_inb), .pwm_bf1_tw(pwm_bf1_tw), .pwm_bf1_result(pwm_bf1_result),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient memories, 2-cycle read BRAM model, result memories.
  logic [LOGQ-1:0] a_mem[N], b0_mem[N], b1_mem[N], c0_mem[N], c1_mem[N];
  logic [LOGQ-1:0] exp0[N], exp1[N], res0_mem[N], res1_mem[N];
  int              wr_pass[N];
  int              wr_total = 0;
  int              pass_id = 0;
  logic [LOGQ-1:0] a_p1, a_p2, b0_p1, b0_p2, b1_p1, b1_p2, c0_p1, c0_p2, c1_p1, c1_p2;

  always @(posedge clk) begin
    a_p1  <= a_mem[a_bram_rd_addr];   a_p2  <= a_p1;
    b0_p1 <= b0_mem[b_bram_rd_addr];  b0_p2 <= b0_p1;
    b1_p1 <= b1_mem[b_bram_rd_addr];  b1_p2 <= b1_p1;
    c0_p1 <= c0_mem[c_bram_rd_addr];  c0_p2 <= c0_p1;
    c1_p1 <= c1_mem[c_bram_rd_addr];  c1_p2 <= c1_p1;
    if (result_bram_wea) begin
      res0_mem[result_bram_wr_addr] <= result0_bram_wr_data;
      res1_mem[result_bram_wr_addr] <= result1_bram_wr_data;
      wr_pass[result_bram_wr_addr]  <= pass_id;
      wr_total <= wr_total + 1;
    end
  end
  assign a_bram_rd_data  = a_p2;
  assign b0_bram_rd_data = b0_p2;
  assign b1_bram_rd_data = b1_p2;
  assign c0_bram_rd_data = c0_p2;
  assign c1_bram_rd_data = c1_p2;

  // Stub butterflies: (ina + inb*tw) mod q with BF_LAT registers.
  function automatic logic [LOGQ-1:0] mac_mod(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y,
                                               input logic [LOGQ-1:0] z);
    logic [127:0] s;
    s = 128'(x) + 128'(y) * 128'(z);
    return LOGQ'(s % Q);
  endfunction

  logic [LOGQ-1:0] bf0_pipe[BF_LAT], bf1_pipe[BF_LAT];
  logic            bf_force = 1'b0;
  logic [LOGQ-1:0] junk0 = '0, junk1 = '0;
  always @(posedge clk) begin
    bf0_pipe[0] <= mac_mod(pwm_bf0_ina, pwm_bf0_inb, pwm_bf0_tw);
    bf1_pipe[0] <= mac_mod(pwm_bf1_ina, pwm_bf1_inb, pwm_bf1_tw);
    for (int i = 1; i < BF_LAT; i++) begin
      bf0_pipe[i] <= bf0_pipe[i-1];
      bf1_pipe[i] <= bf1_pipe[i-1];
    end
  end
  assign pwm_bf0_result = bf_force ? junk0 : bf0_pipe[BF_LAT-1];
  assign pwm_bf1_result = bf_force ? junk1 : bf1_pipe[BF_LAT-1];

  int n_chk = 0, n_fail = 0, cur_t = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cur_t);
    end
  endtask

  function automatic logic [LOGQ-1:0] rnd_q();
    logic [127:0] r;
    r = {64'd0, $urandom, $urandom};
    return LOGQ'(r % Q);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_a"}, 64'(a_bram_rd_addr), 0);
    chk({tag, "_rd_b"}, 64'(b_bram_rd_addr), 0);
    chk({tag, "_rd_c"}, 64'(c_bram_rd_addr), 0);
    chk({tag, "_wea"},  64'(result_bram_wea), 0);
    chk({tag, "_wa"},   64'(result_bram_wr_addr), 0);
    chk({tag, "_wd0"},  64'(result0_bram_wr_data), 0);
    chk({tag, "_wd1"},  64'(result1_bram_wr_data), 0);
    chk({tag, "_bf0"},  64'(pwm_bf0_ina | pwm_bf0_inb | pwm_bf0_tw), 0);
    chk({tag, "_bf1"},  64'(pwm_bf1_ina | pwm_bf1_inb | pwm_bf1_tw), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  // mode 0: a=i, b=2, c=1; mode 1: b1=b0+1, c1=0; mode 2: fully random.
  task automatic load_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        a_mem[i] = LOGQ'(i); b0_mem[i] = 2; b1_mem[i] = 2; c0_mem[i] = 1; c1_mem[i] = 1;
        exp0[i] = LOGQ'(2 * i + 1); exp1[i] = LOGQ'(2 * i + 1);
      end else begin
        a_mem[i] = rnd_q(); b0_mem[i] = rnd_q(); c0_mem[i] = rnd_q();
        b1_mem[i] = (mode == 1) ? LOGQ'((128'(b0_mem[i]) + 1) % Q) : rnd_q();
        c1_mem[i] = (mode == 1) ? '0 : rnd_q();
        exp0[i] = LOGQ'((128'(c0_mem[i]) + 128'(b0_mem[i]) * 128'(a_mem[i])) % Q);
        exp1[i] = LOGQ'((128'(c1_mem[i]) + 128'(b1_mem[i]) * 128'(a_mem[i])) % Q);
      end
    end
  endtask

  typedef struct { int cyc; int rd; bit we; int wa; int d; bit dn; } tvec_t;
  localparam int NTV = 10;
  tvec_t tv[NTV];

  task automatic run_pass(input int mode, input int abort_at);
    int k, base, exp_rd, bad_hi, bad_lo;
    bit exp_we;
    logic [LOGN-1:0] wi, ri;
    rst = 1'b0;
    load_mem(mode);
    repeat (3) @(negedge clk);
    pass_id++;
    base = wr_total;
    k = 0;
    rst = 1'b1;
    for (int t = 0; t < N + LAT + 8; t++) begin
      @(negedge clk);
      cur_t = t;
      exp_rd = (t < N) ? t : N - 1;
      exp_we = (t >= LAT) && (t < N + LAT);
      wi = LOGN'(t - LAT);
      ri = LOGN'(t - RD_LAT);
      if (t < N + LAT) begin
        chk("rd_a", 64'(a_bram_rd_addr), 64'(exp_rd));
        chk("rd_b", 64'(b_bram_rd_addr), 64'(exp_rd));
        chk("rd_c", 64'(c_bram_rd_addr), 64'(exp_rd));
      end
      chk("wea", 64'(result_bram_wea), 64'(exp_we));
      chk("done", 64'(done), 64'(t >= N + LAT));
      if (exp_we) begin
        chk("wr_addr", 64'(result_bram_wr_addr), 64'(wi));
        chk("wr_d0", 64'(result0_bram_wr_data), 64'(exp0[wi]));
        chk("wr_d1", 64'(result1_bram_wr_data), 64'(exp1[wi]));
      end
      if (t >= RD_LAT && t < N + RD_LAT) begin
        chk("bf0_ina", 64'(pwm_bf0_ina), 64'(c0_mem[ri]));
        chk("bf0_inb", 64'(pwm_bf0_inb), 64'(b0_mem[ri]));
        chk("bf0_tw",  64'(pwm_bf0_tw),  64'(a_mem[ri]));
        chk("bf1_ina", 64'(pwm_bf1_ina), 64'(c1_mem[ri]));
        chk("bf1_inb", 64'(pwm_bf1_inb), 64'(b1_mem[ri]));
        chk("bf1_tw",  64'(pwm_bf1_tw),  64'(a_mem[ri]));
      end
      if (mode == 0 && k < NTV && t == tv[k].cyc) begin
        if (tv[k].rd >= 0) chk("tv_rd", 64'(a_bram_rd_addr), 64'(tv[k].rd));
        chk("tv_wea", 64'(result_bram_wea), 64'(tv[k].we));
        if (tv[k].we) begin
          chk("tv_wa", 64'(result_bram_wr_addr), 64'(tv[k].wa));
          chk("tv_d0", 64'(result0_bram_wr_data), 64'(tv[k].d));
          chk("tv_d1", 64'(result1_bram_wr_data), 64'(tv[k].d));
        end
        chk("tv_done", 64'(done), 64'(tv[k].dn));
        k++;
      end
      if (t == abort_at) begin
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (20) begin
          @(negedge clk);
          chk("abort_wea_hold", 64'(result_bram_wea), 0);
          chk("abort_done_hold", 64'(done), 0);
        end
        bad_hi = 0; bad_lo = 0;
        for (int i = 0; i < N; i++) begin
          if (i >= abort_at - LAT) begin
            if (wr_pass[i] == pass_id) bad_hi++;
          end else if (wr_pass[i] != pass_id || res0_mem[i] !== exp0[i] || res1_mem[i] !== exp1[i]) begin
            bad_lo++;
          end
        end
        chk("abort_untouched", 64'(bad_hi), 0);
        chk("abort_prefix", 64'(bad_lo), 0);
        chk("abort_wr_count", 64'(wr_total - base), 64'(abort_at - LAT));
        return;
      end
    end
    bad_lo = 0;
    for (int i = 0; i < N; i++)
      if (wr_pass[i] != pass_id || res0_mem[i] !== exp0[i] || res1_mem[i] !== exp1[i]) bad_lo++;
    chk("mem_sweep", 64'(bad_lo), 0);
    chk("wr_count", 64'(wr_total - base), 64'(N));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    tv[0] = '{0,    0,    1'b0, 0,    0,     1'b0};
    tv[1] = '{1,    1,    1'b0, 0,    0,     1'b0};
    tv[2] = '{9,    9,    1'b0, 0,    0,     1'b0};
    tv[3] = '{10,   10,   1'b1, 0,    1,     1'b0};
    tv[4] = '{11,   11,   1'b1, 1,    3,     1'b0};
    tv[5] = '{8191, 8191, 1'b1, 8181, 16363, 1'b0};
    tv[6] = '{8192, 8191, 1'b1, 8182, 16365, 1'b0};
    tv[7] = '{8201, 8191, 1'b1, 8191, 16383, 1'b0};
    tv[8] = '{8202, 8191, 1'b0, 0,    0,     1'b1};
    tv[9] = '{8210, -1,   1'b0, 0,    0,     1'b1};
    for (int i = 0; i < N; i++) wr_pass[i] = 0;

    rst = 1'b0;
    q_m = QM;
    current_k = 4'd3;
    load_mem(2);
    bf_force = 1'b1;
    repeat (6) begin
      junk0 = rnd_q();
      junk1 = rnd_q();
      @(negedge clk);
      check_all_zero("reset");
    end
    bf_force = 1'b0;

    run_pass(0, -1);
    run_pass(1, -1);
    run_pass(2, -1);
    run_pass(2, 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
